// File: rtl/int32_ascii_serializer.sv
// int32_ascii_serializer
// Turns a stream of signed 32-bit integers into decimal ASCII bytes in the
// format the number-stream parser consumes. Digits come from a repeated
// subtraction against a fixed power-of-ten table, one compare per cycle.
// Leading zeros are suppressed, and a separator or terminator byte follows
// each number.

module int32_ascii_serializer #(
    parameter logic [7:0] SEPARATOR       = 8'h20,
    parameter logic [7:0] TERMINATOR      = 8'h0A,
    parameter bit         EMIT_TERMINATOR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        num_valid,
    input  logic [31:0] num_data,
    input  logic        num_last,
    output logic        num_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic [10:0] num_count,
    output logic        frame_done
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SIGN = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_SEP  = 3'd4;

    localparam logic [7:0]  CHAR_MINUS = 8'h2D;
    localparam logic [7:0]  CHAR_ZERO  = 8'h30;
    localparam logic [10:0] COUNT_MAX  = 11'd2047;

    logic [2:0]  state;
    logic [31:0] mag;
    logic [3:0]  pow_idx;
    logic [3:0]  digit;
    logic        started;
    logic        last_num;
    logic        restart_pending;

    logic [31:0] pow_val;
    logic        mag_ge;
    logic        sep_has_byte;
    logic        accept;
    logic        calc_sub;
    logic        calc_emit;
    logic        calc_skip;
    logic        emit_fire;
    logic        sign_fire;
    logic        sep_done;
    logic [31:0] abs_data;

    // Decimal place values, indexed by digit position (9 = billions)
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        logic [31:0] val;
        case (idx)
            4'd9:    val = 32'd1000000000;
            4'd8:    val = 32'd100000000;
            4'd7:    val = 32'd10000000;
            4'd6:    val = 32'd1000000;
            4'd5:    val = 32'd100000;
            4'd4:    val = 32'd10000;
            4'd3:    val = 32'd1000;
            4'd2:    val = 32'd100;
            4'd1:    val = 32'd10;
            default: val = 32'd1;
        endcase
        return val;
    endfunction

    assign pow_val      = pow10(pow_idx);
    assign mag_ge       = (mag >= pow_val);
    assign sep_has_byte = !last_num || EMIT_TERMINATOR;

    // Magnitude as unsigned, so -2^31 maps cleanly onto 2147483648
    assign abs_data = num_data[31] ? (~num_data + 32'd1) : num_data;

    assign num_ready = (state == ST_IDLE) && !clear;
    assign accept    = num_valid && num_ready;

    assign calc_sub  = (state == ST_CALC) && mag_ge;
    assign calc_emit = (state == ST_CALC) && !mag_ge &&
                       ((digit != 4'd0) || started || (pow_idx == 4'd0));
    assign calc_skip = (state == ST_CALC) && !mag_ge && !calc_emit;
    assign sign_fire = (state == ST_SIGN) && char_ready;
    assign emit_fire = (state == ST_EMIT) && char_ready;
    assign sep_done  = (state == ST_SEP) && (char_ready || !sep_has_byte);

    // Output byte is a pure function of the held state, so it stays stable under stalls
    always_comb begin
        char_valid = 1'b0;
        char_data  = 8'h00;
        case (state)
            ST_SIGN: begin
                char_valid = 1'b1;
                char_data  = CHAR_MINUS;
            end
            ST_EMIT: begin
                char_valid = 1'b1;
                char_data  = CHAR_ZERO + {4'h0, digit};
            end
            ST_SEP: begin
                if (sep_has_byte) begin
                    char_valid = 1'b1;
                    char_data  = last_num ? TERMINATOR : SEPARATOR;
                end
            end
            default: begin
                char_valid = 1'b0;
                char_data  = 8'h00;
            end
        endcase
    end

    // Control FSM: sign, digit search, digit output, trailing separator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= num_data[31] ? ST_SIGN : ST_CALC;
                    end
                end
                ST_SIGN: begin
                    if (sign_fire) begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (calc_emit) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (emit_fire) begin
                        state <= (pow_idx == 4'd0) ? ST_SEP : ST_CALC;
                    end
                end
                ST_SEP: begin
                    if (sep_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Digit datapath: remaining magnitude, place index, running digit, zero suppression
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag      <= 32'd0;
            pow_idx  <= 4'd0;
            digit    <= 4'd0;
            started  <= 1'b0;
            last_num <= 1'b0;
        end else if (clear) begin
            mag      <= 32'd0;
            pow_idx  <= 4'd0;
            digit    <= 4'd0;
            started  <= 1'b0;
            last_num <= 1'b0;
        end else if (accept) begin
            mag      <= abs_data;
            pow_idx  <= 4'd9;
            digit    <= 4'd0;
            started  <= 1'b0;
            last_num <= num_last;
        end else if (calc_sub) begin
            mag   <= mag - pow_val;
            digit <= digit + 4'd1;
        end else if (calc_skip) begin
            pow_idx <= pow_idx - 4'd1;
            digit   <= 4'd0;
        end else if (emit_fire) begin
            started <= 1'b1;
            if (pow_idx != 4'd0) begin
                pow_idx <= pow_idx - 4'd1;
                digit   <= 4'd0;
            end
        end
    end

    // Completed-number counter, saturating, restarted by the first number of a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_count       <= 11'd0;
            restart_pending <= 1'b0;
        end else if (clear) begin
            num_count       <= 11'd0;
            restart_pending <= 1'b0;
        end else if (accept && restart_pending) begin
            num_count       <= 11'd0;
            restart_pending <= 1'b0;
        end else if (sep_done) begin
            if (num_count != COUNT_MAX) begin
                num_count <= num_count + 11'd1;
            end
            if (last_num) begin
                restart_pending <= 1'b1;
            end
        end
    end

    // One-cycle pulse when the last number of a frame has fully gone out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else if (clear) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= sep_done && last_num;
        end
    end

endmodule

// File: tb/tb_int32_ascii_serializer.sv
// tb_int32_ascii_serializer
// Drives two serializers (with and without terminator) from shared inputs and
// compares the selected one against a queue-based decimal formatting model.

module tb_int32_ascii_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        num_valid;
    logic [31:0] num_data;
    logic        num_last;
    logic        char_ready;

    logic        nr1, cv1, fd1;
    logic [7:0]  cd1;
    logic [10:0] cnt1;
    logic        nr0, cv0, fd0;
    logic [7:0]  cd0;
    logic [10:0] cnt0;

    logic        sel;
    logic        s_nr, s_cv, s_fd;
    logic [7:0]  s_cd;
    logic [10:0] s_cnt;

    int total = 0;
    int bad   = 0;

    int          stim_data[$];
    bit          stim_last[$];
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    int32_ascii_serializer #(
        .SEPARATOR(8'h20), .TERMINATOR(8'h0A), .EMIT_TERMINATOR(1'b1)
    ) dut_term (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .num_valid(num_valid), .num_data(num_data), .num_last(num_last),
        .num_ready(nr1), .char_valid(cv1), .char_data(cd1),
        .char_ready(char_ready), .num_count(cnt1), .frame_done(fd1)
    );

    int32_ascii_serializer #(
        .SEPARATOR(8'h20), .TERMINATOR(8'h0A), .EMIT_TERMINATOR(1'b0)
    ) dut_noterm (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .num_valid(num_valid), .num_data(num_data), .num_last(num_last),
        .num_ready(nr0), .char_valid(cv0), .char_data(cd0),
        .char_ready(char_ready), .num_count(cnt0), .frame_done(fd0)
    );

    // Route the instance under test to a common set of observation signals
    always_comb begin
        if (sel) begin
            s_nr = nr1; s_cv = cv1; s_cd = cd1; s_cnt = cnt1; s_fd = fd1;
        end else begin
            s_nr = nr0; s_cv = cv0; s_cd = cd0; s_cnt = cnt0; s_fd = fd0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference formatting: optional '-', decimal digits, then separator/terminator
    function automatic void modelNumber(input int v, input bit last, input bit term);
        longint     m;
        logic [7:0] tmp[$];
        m = longint'(v);
        if (m < 0) begin
            exp_q.push_back(8'h2D);
            m = -m;
        end
        if (m == 0) tmp.push_back(8'h30);
        while (m > 0) begin
            tmp.push_front(8'h30 + 8'(m % 10));
            m = m / 10;
        end
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
        if (!last) exp_q.push_back(8'h20);
        else if (term) exp_q.push_back(8'h0A);
    endfunction

    task automatic doClear();
        @(negedge clk);
        num_valid  = 1'b0;
        char_ready = 1'b0;
        clear      = 1'b1;
        #1;
        checkOutput("clear_blocks_ready", 32'(s_nr), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        checkOutput("clear_count", 32'(s_cnt), 32'd0);
        checkOutput("clear_valid", 32'(s_cv), 32'd0);
        checkOutput("clear_ready", 32'(s_nr), 32'd1);
    endtask

    // Feed stim_data/stim_last into one instance; mode 0 ready=1, 1 toggling, 2 random
    task automatic applyStimulus(input bit term, input int mode, input string tag);
        int         idx = 0;
        int         fd_seen = 0;
        int         exp_frames = 0;
        int         exp_cnt = 0;
        bit         restart = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_cd = 8'h00;
        int         extra = 0;
        int         budget;
        bit         r;
        bit         offer;

        exp_q.delete();
        foreach (stim_data[i]) begin
            modelNumber(stim_data[i], stim_last[i], term);
            if (restart) begin
                exp_cnt = 0;
                restart = 1'b0;
            end
            if (exp_cnt < 2047) exp_cnt++;
            if (stim_last[i]) begin
                exp_frames++;
                restart = 1'b1;
            end
        end
        budget = 200 * stim_data.size() + 40 * exp_q.size() + 50;
        sel = term;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (s_fd) fd_seen++;
            if (prev_stall) begin
                checkOutput({tag, "_hold_valid"}, 32'(s_cv), 32'd1);
                checkOutput({tag, "_hold_data"}, 32'(s_cd), 32'(prev_cd));
            end
            if (s_cv) checkOutput({tag, "_busy_ready"}, 32'(s_nr), 32'd0);

            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(0, 1) == 1);
            endcase
            char_ready = r;
            if (s_cv && r) begin
                if (exp_q.size() == 0)
                    checkOutput({tag, "_extra_byte"}, 32'(s_cd), 32'h100);
                else
                    checkOutput({tag, "_byte"}, 32'(s_cd), 32'(exp_q.pop_front()));
            end
            prev_stall = s_cv && !r;
            prev_cd    = s_cd;

            offer = (mode != 2) || ($urandom_range(0, 3) != 0);
            if (idx < stim_data.size() && offer) begin
                num_valid = 1'b1;
                num_data  = stim_data[idx];
                num_last  = stim_last[idx];
                if (s_nr) idx++;
            end else begin
                num_valid = 1'b0;
            end

            if (idx == stim_data.size() && exp_q.size() == 0) extra++;
            if (extra == 5) break;
        end
        @(negedge clk);
        num_valid = 1'b0;
        if (s_fd) fd_seen++;
        checkOutput({tag, "_leftover"}, 32'(exp_q.size() + stim_data.size() - idx), 32'd0);
        checkOutput({tag, "_frames"}, 32'(fd_seen), 32'(exp_frames));
        checkOutput({tag, "_count"}, 32'(s_cnt), 32'(exp_cnt));
        checkOutput({tag, "_idle_ready"}, 32'(s_nr), 32'd1);
        checkOutput({tag, "_idle_valid"}, 32'(s_cv), 32'd0);
    endtask

    task automatic setStim1(input int v, input bit last);
        stim_data.delete();
        stim_last.delete();
        stim_data.push_back(v);
        stim_last.push_back(last);
    endtask

    task automatic addStim(input int v, input bit last);
        stim_data.push_back(v);
        stim_last.push_back(last);
    endtask

    function automatic int randValue();
        int v;
        case ($urandom_range(0, 5))
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(0, 999));
            2:       v = -int'($urandom_range(0, 99999));
            3:       v = int'(32'h80000000);
            4:       v = 2147483647;
            default: v = int'($urandom_range(0, 9));
        endcase
        return v;
    endfunction

    initial begin
        int got;

        rst_n      = 1'b0;
        clear      = 1'b0;
        num_valid  = 1'b0;
        num_data   = 32'd0;
        num_last   = 1'b0;
        char_ready = 1'b0;
        sel        = 1'b1;

        #12;
        checkOutput("rst_valid", 32'(cv1), 32'd0);
        checkOutput("rst_data", 32'(cd1), 32'd0);
        checkOutput("rst_count", 32'(cnt1), 32'd0);
        checkOutput("rst_frame_done", 32'(fd1), 32'd0);
        checkOutput("rst_ready", 32'(nr1), 32'd1);
        checkOutput("rst_valid_nt", 32'(cv0), 32'd0);
        checkOutput("rst_ready_nt", 32'(nr0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        sel = 1'b1;
        doClear();
        setStim1(0, 1'b1);
        applyStimulus(1'b1, 0, "zero");

        doClear();
        setStim1(123, 1'b0);
        addStim(-45, 1'b1);
        applyStimulus(1'b1, 0, "pair");

        doClear();
        setStim1(int'(32'h80000000), 1'b1);
        applyStimulus(1'b1, 0, "intmin");

        doClear();
        setStim1(2147483647, 1'b1);
        applyStimulus(1'b1, 1, "intmax_toggle");

        // Abort partway through 12345 while '3' is being offered
        sel = 1'b1;
        doClear();
        @(negedge clk);
        num_data   = 32'd12345;
        num_last   = 1'b0;
        num_valid  = 1'b1;
        char_ready = 1'b1;
        @(negedge clk);
        num_valid = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 2; cyc++) begin
            @(negedge clk);
            if (s_cv) begin
                checkOutput("clr_pre_byte", 32'(s_cd), (got == 0) ? 32'h31 : 32'h32);
                got++;
            end
        end
        @(negedge clk);
        char_ready = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (s_cv) break;
            @(negedge clk);
        end
        checkOutput("clr_third", 32'(s_cd), 32'h33);
        clear = 1'b1;
        @(negedge clk);
        checkOutput("clr_valid_drop", 32'(s_cv), 32'd0);
        checkOutput("clr_count", 32'(s_cnt), 32'd0);
        checkOutput("clr_frame_done", 32'(s_fd), 32'd0);
        clear = 1'b0;
        #1;
        checkOutput("clr_ready", 32'(s_nr), 32'd1);
        setStim1(7, 1'b0);
        applyStimulus(1'b1, 0, "after_clear");

        sel = 1'b0;
        doClear();
        setStim1(5, 1'b1);
        addStim(-1000, 1'b0);
        applyStimulus(1'b0, 0, "noterm");

        for (int run = 0; run < 6; run++) begin
            sel = run[0];
            doClear();
            stim_data.delete();
            stim_last.delete();
            for (int k = 0; k < 8; k++) addStim(randValue(), ($urandom_range(0, 3) == 0));
            applyStimulus(run[0], (run < 2) ? run + 1 : 2, "rand");
        end

        sel = 1'b1;
        doClear();
        stim_data.delete();
        stim_last.delete();
        for (int k = 0; k < 2050; k++) addStim(0, 1'b0);
        applyStimulus(1'b1, 0, "saturate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
